// File: rtl/apb_rr_master_arb.sv
// apb_rr_master_arb: round-robin arbiter in front of a single APB master port.
// One local request is granted at a time. Its address, direction and write
// data are latched and the transfer runs through the SETUP and ACCESS phases.
// The requester then gets a completion pulse carrying read data or a timeout
// error. Every output comes straight from a flop.
module apb_rr_master_arb #(
  parameter int NREQ    = 4,
  parameter int AW      = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 rsp_err,
  output logic [AW-1:0]        paddr,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [DW-1:0]        pwdata,
  input  logic [DW-1:0]        prdata,
  input  logic                 pready
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [GW-1:0]       last_grant, last_grant_next;
  logic [GW-1:0]       grant, grant_next;
  logic [GW-1:0]       winner;
  logic [GW:0]         search_idx;
  logic [7:0]          wait_cnt, wait_cnt_next;

  logic [AW-1:0]       addr_arr  [NREQ];
  logic [DW-1:0]       wdata_arr [NREQ];

  logic [NREQ-1:0]     req_ready_next;
  logic [NREQ-1:0]     rsp_valid_next;
  logic [DW-1:0]       rsp_rdata_next;
  logic                rsp_err_next;
  logic [AW-1:0]       paddr_next;
  logic                psel_next;
  logic                penable_next;
  logic                pwrite_next;
  logic [DW-1:0]       pwdata_next;

  // Split the packed request buses into per-requester fields.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_arr[i]  = req_addr[i*AW +: AW];
      wdata_arr[i] = req_wdata[i*DW +: DW];
    end
  end

  // Round-robin search that starts just after the last grant and wraps.
  // The scan runs from the farthest candidate to the nearest, so the nearest valid requester is the one left in winner.
  always_comb begin
    winner     = '0;
    search_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      search_idx = {1'b0, last_grant} + (GW+1)'(k);
      if (search_idx >= (GW+1)'(NREQ)) begin
        search_idx = search_idx - (GW+1)'(NREQ);
      end
      if (req_valid[search_idx[GW-1:0]]) begin
        winner = search_idx[GW-1:0];
      end
    end
  end

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    wait_cnt_next   = wait_cnt;
    paddr_next      = paddr;
    pwrite_next     = pwrite;
    pwdata_next     = pwdata;
    psel_next       = 1'b0;
    penable_next    = 1'b0;
    req_ready_next  = '0;
    rsp_valid_next  = '0;
    rsp_rdata_next  = '0;
    rsp_err_next    = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_next              = SETUP;
          grant_next              = winner;
          last_grant_next         = winner;
          wait_cnt_next           = '0;
          paddr_next              = addr_arr[winner];
          pwrite_next             = req_wr[winner];
          pwdata_next             = req_wr[winner] ? wdata_arr[winner] : '0;
          psel_next               = 1'b1;
          req_ready_next[winner]  = 1'b1;
        end
      end
      SETUP: begin
        state_next   = ACCESS;
        psel_next    = 1'b1;
        penable_next = 1'b1;
      end
      ACCESS: begin
        if (pready) begin
          state_next            = IDLE;
          wait_cnt_next         = '0;
          rsp_valid_next[grant] = 1'b1;
          rsp_rdata_next        = pwrite ? '0 : prdata;
        end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
          state_next            = IDLE;
          wait_cnt_next         = '0;
          rsp_valid_next[grant] = 1'b1;
          rsp_err_next          = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
          psel_next     = 1'b1;
          penable_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs. Reset drops the bus at once and re-arms the pointer so that requester 0 wins first.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NREQ - 1);
      wait_cnt   <= '0;
      paddr      <= '0;
      pwrite     <= 1'b0;
      pwdata     <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
      wait_cnt   <= wait_cnt_next;
      paddr      <= paddr_next;
      pwrite     <= pwrite_next;
      pwdata     <= pwdata_next;
      psel       <= psel_next;
      penable    <= penable_next;
      req_ready  <= req_ready_next;
      rsp_valid  <= rsp_valid_next;
      rsp_rdata  <= rsp_rdata_next;
      rsp_err    <= rsp_err_next;
    end
  end

endmodule

// File: tb/tb_apb_rr_master_arb.sv
// tb_apb_rr_master_arb: scoreboard bench for the round-robin APB arbiter.
// Each requester has a queue of transactions. The reference model works out
// grant order with a plain round-robin search over those queues. It derives
// the responses from the slave's address-indexed wait and read-data tables.
// A monitor pops the expected records whenever the DUT raises req_ready or rsp_valid.
module tb_apb_rr_master_arb;

  localparam int NREQ    = 4;
  localparam int AW      = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 15;

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    int            id;
    logic          err;
    logic [DW-1:0] rdata;
    int            acc_len;
  } rsp_t;

  logic               pclk = 1'b0;
  logic               presetn = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_wr = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic [AW-1:0]      paddr;
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [DW-1:0]      pwdata;
  logic [DW-1:0]      prdata = '0;
  logic               pready = 1'b0;

  txn_t          agent_q [NREQ][$];
  txn_t          exp_grant [$];
  rsp_t          exp_rsp [$];
  int            wait_tbl [16];
  logic [DW-1:0] rd_tbl [16];
  int            grant_cycles [$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            rr_ptr = NREQ - 1;
  int            acc_seen = 0;
  int            slave_acc = 0;
  int            cycle = 0;
  logic [AW-1:0] cur_addr = '0;

  apb_rr_master_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  // Free-running bus clock.
  initial forever #5 pclk = ~pclk;

  // Cycle counter used to measure grant spacing.
  initial forever @(posedge pclk) cycle++;

  // Global watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_req(input int i);
    txn_t t;
    t = agent_q[i][0];
    req_valid[i]           = 1'b1;
    req_wr[i]              = t.wr;
    req_addr[i*AW +: AW]   = t.addr;
    req_wdata[i*DW +: DW]  = t.wdata;
  endtask

  // Reference model: round-robin over every queued transaction, then drive the requests.
  task automatic apply_stimulus();
    int   pos [NREQ];
    int   total;
    int   g;
    int   c;
    int   w;
    txn_t t;
    txn_t eg;
    rsp_t er;
    total = 0;
    for (int i = 0; i < NREQ; i++) begin
      pos[i] = 0;
      total += agent_q[i].size();
    end
    repeat (total) begin
      g = -1;
      for (int k = 1; k <= NREQ; k++) begin
        c = (rr_ptr + k) % NREQ;
        if (g < 0 && pos[c] < agent_q[c].size()) g = c;
      end
      t = agent_q[g][pos[g]];
      pos[g]++;
      eg.id    = g;
      eg.addr  = t.addr;
      eg.wr    = t.wr;
      eg.wdata = t.wr ? t.wdata : '0;
      exp_grant.push_back(eg);
      w          = wait_tbl[t.addr];
      er.id      = g;
      er.err     = (w >= TIMEOUT);
      er.rdata   = (er.err || t.wr) ? '0 : rd_tbl[t.addr];
      er.acc_len = er.err ? TIMEOUT : w + 1;
      exp_rsp.push_back(er);
      rr_ptr = g;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (agent_q[i].size() > 0) load_req(i);
    end
  endtask

  task automatic add_txn(input int i, input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d);
    txn_t t;
    t.id = i; t.addr = a; t.wr = wr; t.wdata = d;
    agent_q[i].push_back(t);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_rsp.size() != 0 || exp_grant.size() != 0) && n < 3000) begin
      @(negedge pclk);
      n++;
    end
    check_output("drain_timeout", 32'(exp_rsp.size() + exp_grant.size()), 32'd0);
    exp_rsp.delete();
    exp_grant.delete();
    @(negedge pclk);
  endtask

  // APB slave: wait states and read data come from the address tables.
  initial forever @(negedge pclk) begin
    if (!presetn) begin
      pready    = 1'b0;
      slave_acc = 0;
    end else if (psel && penable) begin
      pready    = (slave_acc == wait_tbl[paddr]);
      prdata    = rd_tbl[paddr];
      slave_acc++;
    end else begin
      pready    = 1'b0;
      slave_acc = 0;
      prdata    = DW'($urandom);
    end
  end

  // Requester agents: on an accept, move to the next queued transaction or drop valid.
  initial forever @(negedge pclk) begin
    if (presetn) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          if (agent_q[i].size() > 0) void'(agent_q[i].pop_front());
          if (agent_q[i].size() > 0) load_req(i);
          else req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: compare grants, bus stability and completions against the scoreboard.
  initial forever @(negedge pclk) begin
    if (presetn) begin
      if (req_ready != '0) begin
        if (exp_grant.size() == 0) begin
          check_output("unexpected_grant", 32'(req_ready), 32'd0);
        end else begin
          txn_t g;
          g = exp_grant.pop_front();
          check_output("grant_onehot", 32'(req_ready), 32'd1 << g.id);
          check_output("setup_paddr", 32'(paddr), 32'(g.addr));
          check_output("setup_pwrite", 32'(pwrite), 32'(g.wr));
          check_output("setup_pwdata", 32'(pwdata), 32'(g.wdata));
          check_output("setup_psel", 32'(psel), 32'd1);
          check_output("setup_penable", 32'(penable), 32'd0);
          cur_addr = g.addr;
          acc_seen = 0;
          grant_cycles.push_back(cycle);
        end
      end
      if (psel && penable) begin
        acc_seen++;
        check_output("access_paddr_stable", 32'(paddr), 32'(cur_addr));
      end
      if (rsp_valid != '0) begin
        if (exp_rsp.size() == 0) begin
          check_output("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          rsp_t r;
          r = exp_rsp.pop_front();
          check_output("rsp_onehot", 32'(rsp_valid), 32'd1 << r.id);
          check_output("rsp_err", 32'(rsp_err), 32'(r.err));
          check_output("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
          check_output("access_len", 32'(acc_seen), 32'(r.acc_len));
          check_output("rsp_psel_low", 32'(psel), 32'd0);
        end
      end
    end
  end

  // Main sequence: reset, directed scenarios, then randomized batches.
  initial begin
    int wopts [7];
    int n;
    wopts = '{0, 1, 2, 5, 14, 15, 30};
    for (int a = 0; a < 16; a++) begin
      wait_tbl[a] = 0;
      rd_tbl[a]   = DW'($urandom);
    end
    repeat (2) @(negedge pclk);
    check_output("rst_psel", 32'(psel), 32'd0);
    check_output("rst_penable", 32'(penable), 32'd0);
    check_output("rst_req_ready", 32'(req_ready), 32'd0);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_output("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_output("rst_paddr", 32'(paddr), 32'd0);
    check_output("rst_pwdata", 32'(pwdata), 32'd0);
    check_output("rst_pwrite", 32'(pwrite), 32'd0);
    presetn = 1'b1;
    @(negedge pclk);

    $display("[TB] scenario: single write from requester 1");
    wait_tbl[5] = 0;
    add_txn(1, 4'h5, 1'b1, 8'hA3);
    apply_stimulus();
    wait_done();

    $display("[TB] scenario: read with three wait states");
    wait_tbl[9] = 3;
    rd_tbl[9]   = 8'h3C;
    add_txn(0, 4'h9, 1'b0, 8'h77);
    apply_stimulus();
    wait_done();

    $display("[TB] scenario: timeout then normal transfer");
    wait_tbl[12] = 255;
    add_txn(2, 4'hC, 1'b0, 8'h00);
    apply_stimulus();
    wait_done();
    wait_tbl[13] = 1;
    add_txn(3, 4'hD, 1'b1, 8'h5E);
    apply_stimulus();
    wait_done();

    $display("[TB] scenario: all requesters continuously valid");
    for (int i = 0; i < NREQ; i++) begin
      wait_tbl[i] = 0;
      add_txn(i, AW'(i), 1'b1, DW'(8'h10 + i));
      add_txn(i, AW'(i), 1'b0, DW'(8'h20 + i));
    end
    grant_cycles.delete();
    apply_stimulus();
    wait_done();
    check_output("rr_grant_count", 32'(grant_cycles.size()), 32'd8);
    for (int i = 1; i < grant_cycles.size(); i++) begin
      check_output("rr_grant_spacing", 32'(grant_cycles[i] - grant_cycles[i-1]), 32'd3);
    end

    $display("[TB] scenario: withdrawn request is skipped");
    wait_tbl[14] = 4;
    add_txn(2, 4'hE, 1'b0, 8'h00);
    add_txn(2, 4'hE, 1'b1, 8'h99);
    apply_stimulus();
    n = 0;
    while (!req_ready[2] && n < 20) begin
      @(negedge pclk);
      n++;
    end
    check_output("withdraw_first_grant", 32'(req_ready[2]), 32'd1);
    req_valid[3]          = 1'b1;
    req_wr[3]             = 1'b1;
    req_addr[3*AW +: AW]  = 4'hF;
    req_wdata[3*DW +: DW] = 8'h44;
    repeat (5) @(negedge pclk);
    req_valid[3] = 1'b0;
    wait_done();

    $display("[TB] scenario: reset during ACCESS");
    wait_tbl[2] = 40;
    add_txn(1, 4'h2, 1'b1, 8'hC7);
    apply_stimulus();
    n = 0;
    while (!penable && n < 20) begin
      @(negedge pclk);
      n++;
    end
    check_output("reach_access", 32'(penable), 32'd1);
    @(negedge pclk);
    #2 presetn = 1'b0;
    #1;
    check_output("mid_rst_psel", 32'(psel), 32'd0);
    check_output("mid_rst_penable", 32'(penable), 32'd0);
    check_output("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check_output("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < NREQ; i++) agent_q[i].delete();
    exp_grant.delete();
    exp_rsp.delete();
    req_valid = '0;
    rr_ptr    = NREQ - 1;
    acc_seen  = 0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    check_output("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    wait_tbl[0] = 0;
    wait_tbl[1] = 0;
    add_txn(1, 4'h1, 1'b1, 8'h61);
    add_txn(0, 4'h0, 1'b0, 8'h00);
    apply_stimulus();
    wait_done();

    $display("[TB] scenario: randomized batches");
    for (int b = 0; b < 25; b++) begin
      int mask;
      for (int a = 0; a < 16; a++) begin
        wait_tbl[a] = wopts[$urandom_range(0, 6)];
        rd_tbl[a]   = DW'($urandom);
      end
      mask = $urandom_range(1, (1 << NREQ) - 1);
      for (int i = 0; i < NREQ; i++) begin
        if (mask[i]) begin
          int cnt;
          cnt = $urandom_range(1, 3);
          repeat (cnt) add_txn(i, AW'($urandom), 1'($urandom), DW'($urandom));
        end
      end
      apply_stimulus();
      wait_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_rr_master_arb.md
Name: apb_rr_master_arb

Overview:
Round-robin arbiter and APB transfer sequencer that lets NREQ local requesters share one APB master port.
- Grants one request at a time and latches its address, direction and write data.
- Drives the APB setup/access phases and honours pready wait states.
- Returns read data or an error (timeout) to the granted requester.
- Sits between internal clients (config engines, DMA descriptor loaders) and the peripheral APB bus.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 4, APB address width
DW, 8, APB data width
TIMEOUT, 15, max ACCESS cycles without pready before abort (1..255)

Ports:
pclk  input  1  bus clock, all logic on rising edge
presetn  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester transfer request, held until req_ready
req_wr  input  NREQ  per-requester direction, 1=write 0=read
req_addr  input  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
req_wdata  input  NREQ*DW  packed write data, requester i at [i*DW +: DW]
req_ready  output  NREQ  one-hot one-cycle grant/accept pulse
rsp_valid  output  NREQ  one-hot one-cycle completion pulse
rsp_rdata  output  DW  read data, valid with rsp_valid; 0 for writes and errors
rsp_err  output  1  timeout flag, valid with rsp_valid
paddr  output  AW  APB address
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction, 1=write
pwdata  output  DW  APB write data
prdata  input  DW  APB read data
pready  input  1  APB ready

Behaviour:
- Reset (async, presetn=0): state=IDLE.
  - All outputs 0.
  - Wait counter 0.
  - Last-grant pointer = NREQ-1, so requester 0 wins first.
  - Reset mid-transfer abandons it immediately: no rsp_valid is issued, and psel/penable drop asynchronously.
- Outputs are registered; no combinational path from any input to any output.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE → SETUP:
  - Trigger: any req_valid set at the clock edge.
  - Winner g = first requester with valid, searching from (last_grant+1) mod NREQ upward with wrap.
  - At that edge: latch paddr=req_addr[g] and pwrite=req_wr[g].
  - pwdata = req_wdata[g] for a write, 0 for a read.
  - last_grant ← g.
- SETUP cycle (exactly one cycle): psel=1, penable=0, req_ready[g]=1 for this cycle only. Next edge → ACCESS.
- ACCESS cycle(s): psel=1, penable=1; paddr/pwrite/pwdata held stable from SETUP.
  - pready=1 at edge: → IDLE, with next-cycle outputs:
    - psel=0, penable=0.
    - rsp_valid[g]=1 for one cycle, rsp_err=0.
    - rsp_rdata = prdata for a read, 0 for a write.
    - Wait counter cleared.
  - pready=0 at edge: wait counter increments.
  - Timeout: counter reaches TIMEOUT with pready still 0 → IDLE, psel=0, penable=0, rsp_valid[g]=1, rsp_err=1, rsp_rdata=0.
  - pready=1 on the edge where the counter would hit TIMEOUT: normal completion wins.
- After the transfer: paddr/pwrite/pwdata keep their last values in IDLE; only psel/penable are forced to 0.
- IDLE lasts at least one cycle between transfers; back-to-back requests complete at most every 3 cycles with zero wait states.
- Latency, single request, zero wait states:
  - valid sampled at E0 → SETUP during E0–E1, ACCESS during E1–E2.
  - rsp_valid during E2–E3.
- req_valid is ignored outside IDLE.
- Requesters may withdraw req_valid before being granted.
- A requester still asserting valid after its req_ready gets a new transfer only when round-robin order reaches it again.
- Pointer advances only on a grant; a withdrawn request does not move it.
- Round-robin fairness: with all requesters continuously valid, grant order is 0,1,…,NREQ-1,0,…

Test Plan:
1. Reset release, requester 1 writes addr 0x5 data 0xA3, pready tied 1 → req_ready=0b0010 in the SETUP cycle; paddr=5, pwdata=0xA3, pwrite=1, psel high for 2 cycles (penable on the 2nd); rsp_valid=0b0010, rsp_err=0, rsp_rdata=0.
2. Requester 0 reads addr 0x9, prdata=0x3C, pready low for 3 ACCESS cycles → penable high for 4 cycles, paddr stable at 9; rsp_rdata=0x3C, rsp_err=0, rsp_valid=0b0001.
3. All four requesters valid continuously, 8 transfers, pready=1 → grants in order 0,1,2,3,0,1,2,3; transfers spaced 3 cycles apart.
4. Requester 2 read with pready held 0, TIMEOUT=15 → ACCESS lasts exactly 15 cycles, then psel=0, rsp_valid=0b0100, rsp_err=1, rsp_rdata=0; a subsequent request from requester 3 proceeds normally.
5. presetn pulsed low during ACCESS of a requester-1 write → psel/penable/req_ready/rsp_valid go 0 immediately with no rsp_valid; after release with requesters 1 and 0 both valid, requester 0 is granted first.
6. Requester 3 asserts valid then drops it one cycle before IDLE samples, while requester 2 stays valid → requester 2 is granted, requester 3 never sees req_ready.
